// File: rtl/special_key_decoder_pkg.sv
// -----------------------------------------------------------------------------
// special_key_decoder_pkg
//   Shared PS/2 set-2 scan-code constants and FSM state encodings for the
//   special-key scan-code front end.
//   No ports (package).
// -----------------------------------------------------------------------------
package special_key_decoder_pkg;

  // Scan codes (PS/2 set 2)
  localparam logic [7:0] SC_E0    = 8'hE0;  // extended prefix
  localparam logic [7:0] SC_E1    = 8'hE1;  // Pause prefix
  localparam logic [7:0] SC_F0    = 8'hF0;  // break prefix
  localparam logic [7:0] SC_F11   = 8'h78;
  localparam logic [7:0] SC_F12   = 8'h07;
  localparam logic [7:0] SC_SCRLK = 8'h7E;
  localparam logic [7:0] SC_BAT   = 8'hAA;  // self-test passed (keyboard (re)start)
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;
  localparam logic [7:0] SC_FAIL  = 8'hFC;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_E0    = 3'd1;
  localparam logic [2:0] ST_F0    = 3'd2;
  localparam logic [2:0] ST_E0F0  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  // Pause make sequence is E1 followed by seven more bytes
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Bytes that indicate the keyboard restarted or lost sync: every held key
  // must be considered released.
  function automatic logic is_clear_code(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_FAIL) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/special_key_decoder_prefix_timer.sv
// -----------------------------------------------------------------------------
// prefix_timer
//   Saturating cycle counter that measures how long a prefix sequence has been
//   waiting for its next byte.
// Ports:
//   clk       in   system clock
//   reset_n   in   async active-low reset
//   clear_i   in   restart count at 0 (a byte arrived); wins over run_i
//   run_i     in   count this cycle (sequence in progress)
//   expire_o  out  count has reached TO_CYCLES while running
// -----------------------------------------------------------------------------
module prefix_timer #(
  parameter int              TO_W      = 20,
  parameter logic [TO_W-1:0] TO_CYCLES = {TO_W{1'b1}}
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i && (count_q != TO_CYCLES)) begin
      // stop at TO_CYCLES so the counter never wraps back into range
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = run_i && (count_q == TO_CYCLES);

endmodule

// File: rtl/special_key_decoder.sv
// -----------------------------------------------------------------------------
// special_key_decoder
//   Scan-code front end for the special-key handler. Consumes PS/2 set-2 bytes
//   and produces held-key levels for F12, ScrollLock and F11 plus a one-cycle
//   Pause pulse. E0/F0/E1 prefixes are tracked so extended and break codes are
//   never mistaken for the plain keys.
// Ports:
//   clk         in   system clock
//   reset_n     in   async active-low reset
//   rx_data     in   scan-code byte (valid with rx_valid)
//   rx_valid    in   one-cycle byte strobe
//   key_blksbr  out  F12 held
//   key_osd     out  ScrollLock (non-extended) held
//   key_reset   out  F11 held
//   key_pause   out  one-cycle pulse after a complete Pause sequence
//   seq_error   out  one-cycle pulse when a prefix is abandoned by timeout
// -----------------------------------------------------------------------------
module special_key_decoder
  import special_key_decoder_pkg::*;
#(
  parameter int              TO_W      = 20,
  parameter logic [TO_W-1:0] TO_CYCLES = {TO_W{1'b1}}
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_blksbr,
  output logic       key_osd,
  output logic       key_reset,
  output logic       key_pause,
  output logic       seq_error
);

  logic [2:0] state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       blksbr_q, blksbr_d;
  logic       osd_q, osd_d;
  logic       rst_q, rst_d;
  logic       pause_q, pause_d;
  logic       err_q, err_d;
  logic       expire;

  prefix_timer #(
    .TO_W      (TO_W),
    .TO_CYCLES (TO_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (rx_valid),
    .run_i    (state_q != ST_IDLE),
    .expire_o (expire)
  );

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    blksbr_d = blksbr_q;
    osd_d    = osd_q;
    rst_d    = rst_q;
    pause_d  = 1'b0;
    err_d    = 1'b0;

    // A byte arriving on the expiry cycle is processed normally; the timeout
    // only acts when the line stayed silent.
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_E0) begin
            state_d = ST_E0;
          end else if (rx_data == SC_F0) begin
            state_d = ST_F0;
          end else if (rx_data == SC_E1) begin
            state_d = ST_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (is_clear_code(rx_data)) begin
            blksbr_d = 1'b0;
            osd_d    = 1'b0;
            rst_d    = 1'b0;
          end else if (rx_data == SC_F12) begin
            blksbr_d = 1'b1;
          end else if (rx_data == SC_SCRLK) begin
            osd_d = 1'b1;
          end else if (rx_data == SC_F11) begin
            rst_d = 1'b1;
          end
        end
        ST_F0: begin
          if (rx_data == SC_F12)   blksbr_d = 1'b0;
          if (rx_data == SC_SCRLK) osd_d    = 1'b0;
          if (rx_data == SC_F11)   rst_d    = 1'b0;
          state_d = ST_IDLE;
        end
        ST_E0: begin
          // E0 7E is Ctrl+Break, not ScrollLock: only E0 F0 keeps us in a prefix
          state_d = (rx_data == SC_F0) ? ST_E0F0 : ST_IDLE;
        end
        ST_E0F0: begin
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          // content of the Pause tail is not inspected, only counted
          if (skip_q <= 3'd1) begin
            skip_d  = '0;
            state_d = ST_IDLE;
            pause_d = 1'b1;
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          skip_d  = '0;
        end
      endcase
    end else if (expire) begin
      state_d = ST_IDLE;
      skip_d  = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      skip_q   <= '0;
      blksbr_q <= 1'b0;
      osd_q    <= 1'b0;
      rst_q    <= 1'b0;
      pause_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      blksbr_q <= blksbr_d;
      osd_q    <= osd_d;
      rst_q    <= rst_d;
      pause_q  <= pause_d;
      err_q    <= err_d;
    end
  end

  assign key_blksbr = blksbr_q;
  assign key_osd    = osd_q;
  assign key_reset  = rst_q;
  assign key_pause  = pause_q;
  assign seq_error  = err_q;

endmodule

// File: tb/tb_special_key_decoder.sv
module tb_special_key_decoder;

  localparam int              TO_W   = 8;
  localparam logic [TO_W-1:0] TO_CYC = 8'd30;
  localparam int              TO     = 30;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       key_blksbr, key_osd, key_reset, key_pause, seq_error;

  special_key_decoder #(
    .TO_W      (TO_W),
    .TO_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .key_blksbr (key_blksbr),
    .key_osd    (key_osd),
    .key_reset  (key_reset),
    .key_pause  (key_pause),
    .seq_error  (seq_error)
  );

  always #5 clk = ~clk;

  // expected {blksbr, osd, reset, pause, error} for the cycle after each edge
  typedef logic [4:0] exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pauses_seen = 0;
  int errs_seen = 0;

  // Reference model: the bytes of the unfinished sequence, silence length,
  // and the three key levels.
  logic [7:0] seq[$];
  int         age = 0;
  bit         m_blk = 0, m_osd = 0, m_rst = 0;

  task automatic model_byte(input logic [7:0] d, output bit p);
    p = 0;
    seq.push_back(d);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) begin
        p = 1;
        seq.delete();
      end
    end else if (seq.size() == 1) begin
      if (d != 8'hE0 && d != 8'hF0) begin
        if (d == 8'hAA || d == 8'hFC || d == 8'hFF) begin
          m_blk = 0; m_osd = 0; m_rst = 0;
        end
        if (d == 8'h07) m_blk = 1;
        if (d == 8'h7E) m_osd = 1;
        if (d == 8'h78) m_rst = 1;
        seq.delete();
      end
    end else if (seq.size() == 2 && seq[0] == 8'hF0) begin
      if (d == 8'h07) m_blk = 0;
      if (d == 8'h7E) m_osd = 0;
      if (d == 8'h78) m_rst = 0;
      seq.delete();
    end else if (seq.size() == 2) begin
      if (d != 8'hF0) seq.delete();
    end else begin
      seq.delete();
    end
  endtask

  // one clock cycle of stimulus; byte presented if v
  task automatic step(input bit v, input logic [7:0] d);
    bit p, e;
    @(negedge clk);
    reset_n  = 1'b1;
    rx_valid = v;
    rx_data  = v ? d : 8'h00;
    p = 0;
    e = 0;
    if (v) begin
      model_byte(d, p);
      age = 0;
    end else if (seq.size() > 0) begin
      if (age == TO) begin
        seq.delete();
        e = 1;
      end else begin
        age++;
      end
    end
    exp_q.push_back({m_blk, m_osd, m_rst, p, e});
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      seq.delete();
      age = 0;
      m_blk = 0; m_osd = 0; m_rst = 0;
      exp_q.push_back(5'b0);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard once per cycle
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {key_blksbr, key_osd, key_reset, key_pause, seq_error};
      checks++;
      if (a[1]) pauses_seen++;
      if (a[0]) errs_seen++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual blk/osd/rst/pause/err=%b expected=%b", $time, a, e);
      end
      if (key_pause && seq_error) begin
        errors++;
        $display("FAIL pause_err_overlap t=%0t actual=11 expected=not both", $time);
      end
    end
  end

  logic [7:0] pool [12] = '{8'h07, 8'h7E, 8'h78, 8'hE0, 8'hF0, 8'hE1,
                            8'hAA, 8'hFC, 8'hFF, 8'h00, 8'h14, 8'h77};

  initial begin
    int p0;
    do_reset(3);
    idle(2);

    // 1: F12 make/break
    send(8'h07); idle(2); send(8'hF0); send(8'h07); idle(2);
    // 2: Break (E0 7E E0 F0 7E) must not touch ScrollLock
    send(8'hE0); send(8'h7E); send(8'hE0); send(8'hF0); send(8'h7E); idle(2);
    // 3: Pause sequence gives exactly one pulse
    p0 = pauses_seen;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); idle(3);
    checks++;
    if (pauses_seen - p0 != 1) begin
      errors++;
      $display("FAIL pause_count actual=%0d expected=1", pauses_seen - p0);
    end
    // 4: prefix abandoned by timeout, held level survives, then released
    send(8'h7E); send(8'hE0); idle(TO + 5);
    send(8'hF0); send(8'h7E); idle(2);
    // 5: clear code drops F11, typematic F12 repeats
    send(8'h78); idle(1); send(8'hAA); idle(1);
    send(8'h07); send(8'h07); idle(1); send(8'h07); idle(2);
    send(8'hF0); send(8'h07);
    // 6: byte on the exact expiry cycle wins; then one cycle later times out
    send(8'hE0); idle(TO); send(8'h7E); idle(2);
    send(8'hE0); idle(TO + 1); send(8'h7E); idle(2);
    send(8'hF0); send(8'h7E);
    // 7: reset in the middle of a Pause sequence
    send(8'h78); send(8'hE1); send(8'h14);
    do_reset(2);
    send(8'h77); idle(1); send(8'h07); idle(2);
    // Pause interrupted by timeout
    send(8'hE1); send(8'h14); idle(TO + 3); send(8'h78); idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) send(pool[$urandom_range(0, 11)]);
      else send(8'($urandom));
      case ($urandom_range(0, 19))
        0:       idle($urandom_range(TO - 2, TO + 3));
        1:       do_reset(1);
        2, 3:    idle($urandom_range(1, 4));
        default: ;
      endcase
    end

    idle(3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d left expected=0", exp_q.size());
    end
    checks++;
    if (errs_seen == 0) begin
      errors++;
      $display("FAIL seq_error_seen actual=0 expected=nonzero");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
